nco_control: RTL and testbench
==============================

# nco_control

Front-panel control stage of the NCO, directly upstream of the waveform generator. It debounces three active-low push-buttons and runs the mode state machine that selects waveform and output frequency. It drives the generator's sample clock `clk_out`, mode code `state_out` and waveform select `signal_out`. The generator advances its lookup-table address only while `state_out == 5`; this block guarantees `clk_out` is quiet in every other state.

## Interface
- `DEBOUNCE_CYC`, default 1_000_000: consecutive equal samples (20 ms at 50 MHz) needed to accept a key level; range 2..2^20.
- `HALF_BASE`, default 1563: base half-period of `clk_out` in `clk_50MHz` cycles; range 1..4095.
- `clk_50MHz` in 1: system clock. One clock; all logic is in this domain.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `key_next_n` in 1: next-state button, active-low, asynchronous to `clk_50MHz`.
- `key_up_n` in 1: increment button, active-low, asynchronous.
- `key_down_n` in 1: decrement button, active-low, asynchronous.
- `clk_out` out 1: registered divided sample clock for the generator.
- `state_out` out 3: current mode code, 0..5.
- `signal_out` out 4: waveform select, 1..6 (sine, cosine, triangle, sinc, sawtooth, square).
- `freq_code` out 4: frequency code, 0..15; a higher code gives a higher frequency.

## Operation
- **Key conditioning, per key:** 2-FF synchronizer, then a stability counter. The debounced level updates after `DEBOUNCE_CYC` consecutive equal synchronized samples. Each debounced high→low transition emits one 1-cycle press event. Releases emit nothing.
- **Same-cycle key priority:** a `next` event dominates, so any up or down event in that cycle is dropped. Up and down together: both are dropped.
- **States** (`state_out` encoding):
  - **IDLE=0**: `next` → WAVE.
  - **WAVE=1**: up/down step `signal_out` with wrap-around, 6+1→1 and 1−1→6. `next` → FREQ.
  - **FREQ=2**: up/down step `freq_code`, saturating at 0 and 15. `next` → LOAD.
  - **LOAD=3**: lasts exactly 1 cycle. Latches the half-period `H = HALF_BASE*(16−freq_code)` (16-bit), clears the divider counter, holds `clk_out` at 0. Then → ARM.
  - **ARM=4**: lasts exactly 4 cycles so the generator settles its table before stepping. Then → RUN.
  - **RUN=5**: divider active. Up/down step `freq_code` (saturating) immediately. The new `H` is staged and applied only when `clk_out` falls. `next` → IDLE.
- **Divider (RUN only):**
  - 16-bit counter counts 0..H−1.
  - At H−1 the counter returns to 0 and `clk_out` toggles.
  - A staged `H` loads at the counter wrap that drives `clk_out` 1→0.
- **Leaving RUN:** `clk_out` forced to 0 in the first cycle of IDLE. The counter clears. `signal_out` and `freq_code` hold.
- **Outside RUN:** `clk_out` is 0 and the divider counter is held at 0.
- Keys pressed during LOAD or ARM are discarded.
- **Reset (async, any time including mid-RUN):** `state_out`=0, `signal_out`=1, `freq_code`=0, `clk_out`=0. Counters and debounced levels clear to "released". No press event is generated on reset release while a key is held.

## Timing
- **Press event latency:** appears 2 (sync) + `DEBOUNCE_CYC` cycles after the pin settles low.
- **Register updates:** `state_out`, `signal_out` and `freq_code` update on the edge after the event cycle.
- **FREQ→RUN:** `next` event at cycle t puts `state_out`=3 at t+1, 4 at t+2..t+5, and 5 at t+6.
- **First `clk_out` edge:** first rise H cycles after `state_out` becomes 5. Period 2H; duty exactly 50%.
- **Output waveform frequency:** 50 MHz / (2H·32).
- **Glitch-free:** `clk_out` comes directly from a flop.

## Structure
- **`nco_pkg`:**
  - `state_t` enum with IDLE..RUN and the fixed encodings 0..5.
  - `SIG_MIN`=1, `SIG_MAX`=6, `FREQ_MAX`=15.
  - `ARM_CYC`=4.
- **Sub-module `key_debounce`** (parameter `DEBOUNCE_CYC`; ports `clk_50MHz`, `rst_n`, `key_n`, `press`): instantiated three times.
- **Top level:** FSM, divider and staging registers.

## Test plan
Use `DEBOUNCE_CYC`=4 and `HALF_BASE`=2 throughout.
- **Reset:** assert `rst_n`=0 mid-RUN → same-cycle `clk_out`=0, `state_out`=0, `signal_out`=1, `freq_code`=0.
- **Debounce:**
  - 3-cycle low glitch on `key_up_n` in WAVE → no change.
  - 10-cycle low → `signal_out` 1→2 exactly once, 7 cycles after the falling pin.
- **Waveform wrap:**
  - Press up 6 times in WAVE from 1 → sequence 2,3,4,5,6,1.
  - Press down once at 1 → 6.
  - `next` and up in the same cycle → state advances, `signal_out` unchanged.
- **Frequency saturation:**
  - Up 20 times in FREQ → `freq_code`=15.
  - Down 20 times → 0, never wraps.
- **RUN timing:** `freq_code`=14 (H=4), `next` from FREQ → `state_out` 3,4,4,4,4,5. First `clk_out` rise 4 cycles into RUN, then period 8.
- **Live frequency change:** up during `clk_out` high in RUN (code 14→15, H=2) → current high phase completes at 4 cycles; after the fall, half-periods are 2 cycles. `next` → `clk_out`=0 and `state_out`=0 on the following cycle.

Source files
------------

// File: rtl/nco_pkg.sv
// Shared types and constants for the NCO front-panel controller.
package nco_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAVE = 3'd1,
    FREQ = 3'd2,
    LOAD = 3'd3,
    ARM  = 3'd4,
    RUN  = 3'd5
  } state_t;

  localparam logic [3:0] SIG_MIN  = 4'd1;
  localparam logic [3:0] SIG_MAX  = 4'd6;
  localparam logic [3:0] FREQ_MAX = 4'd15;
  localparam int         ARM_CYC  = 4;

  function automatic logic [15:0] half_period(input logic [15:0] base, input logic [3:0] code);
    return base * (16'd16 - {12'd0, code});
  endfunction

  function automatic logic [3:0] freq_step(input logic [3:0] code, input logic up, input logic down);
    logic [3:0] res;
    res = code;
    if (up && code != FREQ_MAX)
      res = code + 4'd1;
    else if (down && code != 4'd0)
      res = code - 4'd1;
    return res;
  endfunction

  function automatic logic [3:0] sig_step(input logic [3:0] sig, input logic up, input logic down);
    logic [3:0] res;
    res = sig;
    if (up)
      res = (sig == SIG_MAX) ? SIG_MIN : sig + 4'd1;
    else if (down)
      res = (sig == SIG_MIN) ? SIG_MAX : sig - 4'd1;
    return res;
  endfunction

endpackage

// File: rtl/nco_control_key_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability down-counter, one-cycle press pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk_50MHz,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int             CW       = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(DEBOUNCE_CYC - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_armed;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // Synchronizer resets to "pressed" and the filter stays idle until a released
  // level is seen, so a key held through reset never produces a press.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_armed <= 1'b0;
      r_level <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= CNT_LOAD;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      r_armed <= r_armed | r_sync2;
      r_press <= 1'b0;
      if (!r_armed || r_sync2 == r_level) begin
        r_cnt <= CNT_LOAD;
      end else if (r_cnt == '0) begin
        r_level <= r_sync2;
        r_press <= ~r_sync2;
        r_cnt   <= CNT_LOAD;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign press = r_press;

endmodule

// File: rtl/nco_control.sv
// NCO mode controller: key arbitration, mode FSM and glitch-free clk_out divider.
//   state | meaning
//   IDLE  | waiting for next
//   WAVE  | up/down select waveform (wraps 1..6)
//   FREQ  | up/down select frequency code (saturates 0..15)
//   LOAD  | latch half-period, one cycle
//   ARM   | generator settle, ARM_CYC cycles
//   RUN   | divider running, live frequency changes
import nco_pkg::*;

module nco_control #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int HALF_BASE    = 1563
) (
  input  logic       clk_50MHz,
  input  logic       rst_n,
  input  logic       key_next_n,
  input  logic       key_up_n,
  input  logic       key_down_n,
  output logic       clk_out,
  output logic [2:0] state_out,
  output logic [3:0] signal_out,
  output logic [3:0] freq_code
);

  localparam logic [15:0]   BASE     = 16'(HALF_BASE);
  localparam int            AW       = $clog2(ARM_CYC);
  localparam logic [AW-1:0] ARM_LOAD = AW'(ARM_CYC - 1);

  logic          w_press_next, w_press_up, w_press_down;
  logic          w_next, w_up, w_down;
  state_t        r_state, w_state_nx;
  logic [3:0]    r_sig, w_sig_nx;
  logic [3:0]    r_freq, w_freq_nx;
  logic [AW-1:0] r_arm_cnt, w_arm_cnt_nx;
  logic [15:0]   r_div_cnt, w_div_cnt_nx;
  logic [15:0]   r_half, w_half_nx, w_half_stg;
  logic          r_clk, w_clk_nx;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_next (
    .clk_50MHz(clk_50MHz), .rst_n(rst_n), .key_n(key_next_n), .press(w_press_next));
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_up (
    .clk_50MHz(clk_50MHz), .rst_n(rst_n), .key_n(key_up_n), .press(w_press_up));
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_down (
    .clk_50MHz(clk_50MHz), .rst_n(rst_n), .key_n(key_down_n), .press(w_press_down));

  assign w_next     = w_press_next;
  assign w_up       = w_press_up & ~w_press_down & ~w_press_next;
  assign w_down     = w_press_down & ~w_press_up & ~w_press_next;
  assign w_half_stg = half_period(BASE, r_freq);

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_sig     <= SIG_MIN;
      r_freq    <= 4'd0;
      r_arm_cnt <= '0;
      r_div_cnt <= 16'd0;
      r_half    <= half_period(BASE, 4'd0);
      r_clk     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_sig     <= w_sig_nx;
      r_freq    <= w_freq_nx;
      r_arm_cnt <= w_arm_cnt_nx;
      r_div_cnt <= w_div_cnt_nx;
      r_half    <= w_half_nx;
      r_clk     <= w_clk_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_sig_nx     = r_sig;
    w_freq_nx    = r_freq;
    w_arm_cnt_nx = r_arm_cnt;
    w_div_cnt_nx = 16'd0;
    w_half_nx    = r_half;
    w_clk_nx     = 1'b0;
    case (r_state)
      IDLE: if (w_next) w_state_nx = WAVE;
      WAVE: begin
        if (w_next) w_state_nx = FREQ;
        else        w_sig_nx   = sig_step(r_sig, w_up, w_down);
      end
      FREQ: begin
        if (w_next) w_state_nx = LOAD;
        else        w_freq_nx  = freq_step(r_freq, w_up, w_down);
      end
      LOAD: begin
        w_half_nx    = w_half_stg;
        w_arm_cnt_nx = ARM_LOAD;
        w_state_nx   = ARM;
      end
      ARM: begin
        if (r_arm_cnt == '0) w_state_nx   = RUN;
        else                 w_arm_cnt_nx = r_arm_cnt - 1'b1;
      end
      RUN: begin
        if (w_next) begin
          w_state_nx = IDLE;
        end else begin
          w_freq_nx = freq_step(r_freq, w_up, w_down);
          w_clk_nx  = r_clk;
          if (r_div_cnt == r_half - 16'd1) begin
            w_clk_nx = ~r_clk;
            // a new half-period only takes effect on the falling toggle
            if (r_clk) w_half_nx = w_half_stg;
          end else begin
            w_div_cnt_nx = r_div_cnt + 16'd1;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign clk_out    = r_clk;
  assign state_out  = r_state;
  assign signal_out = r_sig;
  assign freq_code  = r_freq;

endmodule

// File: tb/tb_nco_control.sv
// Self-checking bench for nco_control: cycle-level behavioural model plus directed literal checks.
module tb_nco_control;

  localparam int D  = 4;
  localparam int HB = 2;

  logic       clk_50MHz  = 1'b0;
  logic       rst_n      = 1'b0;
  logic       key_next_n = 1'b1;
  logic       key_up_n   = 1'b1;
  logic       key_down_n = 1'b1;
  logic       clk_out;
  logic [2:0] state_out;
  logic [3:0] signal_out;
  logic [3:0] freq_code;

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  nco_control #(.DEBOUNCE_CYC(D), .HALF_BASE(HB)) dut (
    .clk_50MHz (clk_50MHz),
    .rst_n     (rst_n),
    .key_next_n(key_next_n),
    .key_up_n  (key_up_n),
    .key_down_n(key_down_n),
    .clk_out   (clk_out),
    .state_out (state_out),
    .signal_out(signal_out),
    .freq_code (freq_code)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  // ---------------- behavioural model ----------------
  int m_state, m_sig, m_freq, m_arm, m_since, m_H;
  bit m_clk;
  bit m_db[3];
  bit m_ev[3];
  bit m_hist[3][$];

  function automatic int half_of(input int f);
    return HB * (16 - f);
  endfunction

  function automatic int sat(input int v);
    if (v < 0)  return 0;
    if (v > 15) return 15;
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_sig = 1; m_freq = 0; m_arm = 0; m_since = 0; m_H = half_of(0); m_clk = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_db[k] = 1'b1;
      m_ev[k] = 1'b0;
      m_hist[k].delete();
      for (int j = 0; j < D + 2; j++) m_hist[k].push_back(1'b1);
    end
  endtask

  task automatic model_step();
    bit nx, up, dn, w, all;
    bit pins[3];
    int n, delta;
    pins[0] = key_next_n; pins[1] = key_up_n; pins[2] = key_down_n;
    nx = m_ev[0];
    up = m_ev[1] && !m_ev[2] && !nx;
    dn = m_ev[2] && !m_ev[1] && !nx;
    delta = (up ? 1 : 0) - (dn ? 1 : 0);
    case (m_state)
      0: if (nx) m_state = 1;
      1: begin
        if (nx)      m_state = 2;
        else if (up) m_sig = m_sig % 6 + 1;
        else if (dn) m_sig = (m_sig + 4) % 6 + 1;
      end
      2: begin
        if (nx) m_state = 3;
        else    m_freq = sat(m_freq + delta);
      end
      3: begin
        m_H = half_of(m_freq); m_arm = 4; m_since = 0; m_clk = 1'b0; m_state = 4;
      end
      4: begin
        m_arm--;
        if (m_arm == 0) m_state = 5;
      end
      default: begin
        if (nx) begin
          m_state = 0; m_clk = 1'b0; m_since = 0;
        end else begin
          m_since++;
          if (m_since == m_H) begin
            m_since = 0;
            if (m_clk) m_H = half_of(m_freq);
            m_clk = !m_clk;
          end
          m_freq = sat(m_freq + delta);
        end
      end
    endcase
    // a key level is accepted once the last D synchronized samples agree and differ from it
    for (int k = 0; k < 3; k++) begin
      m_hist[k].push_back(pins[k]);
      n   = m_hist[k].size();
      w   = m_hist[k][n-3];
      all = 1'b1;
      for (int j = 0; j < D; j++) if (m_hist[k][n-3-j] != w) all = 1'b0;
      m_ev[k] = 1'b0;
      if (all && w != m_db[k]) begin
        m_db[k] = w;
        m_ev[k] = !w;
      end
      while (m_hist[k].size() > D + 2) void'(m_hist[k].pop_front());
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_50MHz or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  initial begin
    forever begin
      @(negedge clk_50MHz);
      if (cmp_en) begin
        chk("model clk_out",    32'(clk_out),    32'(m_clk));
        chk("model state_out",  32'(state_out),  32'(m_state));
        chk("model signal_out", 32'(signal_out), 32'(m_sig));
        chk("model freq_code",  32'(freq_code),  32'(m_freq));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0:       key_next_n = v;
      1:       key_up_n   = v;
      default: key_down_n = v;
    endcase
  endtask

  task automatic press(input int k, input int len, input int gap);
    set_key(k, 1'b0);
    repeat (len) tick();
    set_key(k, 1'b1);
    repeat (gap) tick();
  endtask

  task automatic rand_presses(input int n);
    int sel, len, gap;
    for (int i = 0; i < n; i++) begin
      sel = int'($urandom_range(0, 2));
      len = int'($urandom_range(1, 8));
      gap = int'($urandom_range(0, 10));
      if (sel == 2) begin key_up_n = 1'b0; key_down_n = 1'b0; end
      else          set_key(sel + 1, 1'b0);
      repeat (len) tick();
      key_up_n = 1'b1; key_down_n = 1'b1;
      repeat (gap) tick();
    end
    repeat (14) tick();
  endtask

  initial begin
    int exp_seq[5];
    int sig_before;
    bit ok;
    exp_seq = '{3, 4, 5, 6, 1};

    repeat (3) tick();
    rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk_50MHz);
    chk("reset state_out",  32'(state_out),  32'd0);
    chk("reset signal_out", 32'(signal_out), 32'd1);
    chk("reset freq_code",  32'(freq_code),  32'd0);
    chk("reset clk_out",    32'(clk_out),    32'd0);
    repeat (5) tick();

    press(0, 8, 12);
    @(negedge clk_50MHz);
    chk("enter WAVE", 32'(state_out), 32'd1);
    tick();

    press(1, 3, 12);
    @(negedge clk_50MHz);
    chk("glitch ignored", 32'(signal_out), 32'd1);
    tick();

    key_up_n = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 10) key_up_n = 1'b1;
      @(negedge clk_50MHz);
      if (i == 6)  chk("debounce before 7", 32'(signal_out), 32'd1);
      if (i == 7)  chk("debounce at 7",     32'(signal_out), 32'd2);
      if (i == 12) chk("debounce once",     32'(signal_out), 32'd2);
    end
    repeat (6) tick();

    for (int i = 0; i < 5; i++) begin
      press(1, 6, 10);
      @(negedge clk_50MHz);
      chk("wave up wrap", 32'(signal_out), 32'(exp_seq[i]));
      tick();
    end
    press(2, 6, 10);
    @(negedge clk_50MHz);
    chk("wave down wrap", 32'(signal_out), 32'd6);
    tick();

    rand_presses(12);

    sig_before = m_sig;
    key_next_n = 1'b0; key_up_n = 1'b0;
    repeat (8) tick();
    key_next_n = 1'b1; key_up_n = 1'b1;
    repeat (12) tick();
    @(negedge clk_50MHz);
    chk("next+up state",  32'(state_out),  32'd2);
    chk("next+up signal", 32'(signal_out), 32'(sig_before));
    tick();

    repeat (20) press(1, 6, 10);
    @(negedge clk_50MHz);
    chk("freq sat high", 32'(freq_code), 32'd15);
    tick();
    repeat (20) press(2, 6, 10);
    @(negedge clk_50MHz);
    chk("freq sat low", 32'(freq_code), 32'd0);
    tick();
    repeat (14) press(1, 6, 10);
    @(negedge clk_50MHz);
    chk("freq 14", 32'(freq_code), 32'd14);
    tick();

    key_next_n = 1'b0;
    for (int i = 1; i <= 34; i++) begin
      tick();
      if (i == 10) key_next_n = 1'b1;
      if (i == 20) key_up_n = 1'b0;
      if (i == 28) key_up_n = 1'b1;
      @(negedge clk_50MHz);
      case (i)
        7:                chk("run seq LOAD", 32'(state_out), 32'd3);
        8, 9, 10, 11:     chk("run seq ARM",  32'(state_out), 32'd4);
        12:               chk("run seq RUN",  32'(state_out), 32'd5);
        13, 14, 15:       chk("first rise low",  32'(clk_out), 32'd0);
        16, 19:           chk("first high",      32'(clk_out), 32'd1);
        20:               chk("first fall",      32'(clk_out), 32'd0);
        24:               chk("second rise",     32'(clk_out), 32'd1);
        27: begin
          chk("live freq 15", 32'(freq_code), 32'd15);
          chk("live high held", 32'(clk_out), 32'd1);
        end
        28, 29:           chk("live fall",  32'(clk_out), 32'd0);
        30, 31:           chk("live H2 high", 32'(clk_out), 32'd1);
        32:               chk("live H2 low",  32'(clk_out), 32'd0);
        default: ;
      endcase
    end
    repeat (12) tick();

    rand_presses(10);

    key_next_n = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      @(negedge clk_50MHz);
      if (i == 6) chk("still RUN", 32'(state_out), 32'd5);
      if (i == 7) begin
        chk("exit RUN state", 32'(state_out), 32'd0);
        chk("exit RUN clk",   32'(clk_out),   32'd0);
      end
    end
    tick();
    key_next_n = 1'b1;
    repeat (12) tick();

    repeat (3) press(0, 8, 12);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk_50MHz);
      if (clk_out === 1'b1) ok = 1'b1;
    end
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL wait clk_out high: got 0, expected 1 within 200 cycles");
    #2 rst_n = 1'b0;
    #1;
    chk("async reset clk_out",    32'(clk_out),    32'd0);
    chk("async reset state_out",  32'(state_out),  32'd0);
    chk("async reset signal_out", 32'(signal_out), 32'd1);
    chk("async reset freq_code",  32'(freq_code),  32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    press(0, 8, 12);
    @(negedge clk_50MHz);
    chk("after reset WAVE", 32'(state_out), 32'd1);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
